burst_mem_responder: RTL and testbench
======================================

# burst_mem_responder

Synthesizable memory-side responder for the 64-bit physical-memory burst interface driven by the cache subsystem's arbiter and cacheline adapter. It accepts one cacheline request at a time, waits a programmable access latency, then answers with a 4-beat burst that carries or absorbs a 256-bit line. It stands in for DRAM in FPGA and simulation builds, and serves as the reference responder for cache-side verification.

## Interface
- `DEPTH_LOG2`, default 8: line-store depth is 2^DEPTH_LOG2 lines of 256 bits.
- `LATENCY`, default 6: cycles from request detection to first response beat; legal range 1..255.
- `clk` input 1: sole clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pmem_read` input 1: line read request; held until the burst completes.
- `pmem_write` input 1: line write request; held until the burst completes.
- `pmem_address` input 32: line address; bits [4:0] are ignored.
- `pmem_wdata` input 64: write beat data; sampled on every cycle that `pmem_resp` is high during a write.
- `pmem_resp` output 1: high for each of the 4 beat cycles.
- `pmem_rdata` output 64: read beat data; valid when `pmem_resp` is high, 0 otherwise.
- `proto_err` output 1: sticky protocol-violation flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, BURST, DONE.
- IDLE: the block stays here until `pmem_read` or `pmem_write` is high. On detection it latches the op (write wins over read) and the line index `pmem_address[5+DEPTH_LOG2-1:5]`, loads the latency counter, and moves to WAIT.
- Upper address bits above the index are ignored, so addresses alias modulo 2^DEPTH_LOG2 lines.
- WAIT: the counter counts down. When it expires the block moves to BURST with beat counter 0.
- BURST: `pmem_resp` is high for 4 consecutive cycles, beats b = 0..3.
  - Beat b maps to line bits [64b+63:64b].
  - Read: `pmem_rdata` = stored beat b.
  - Write: `pmem_wdata` is written into beat b at the clock edge.
  - After beat 3 the block moves to DONE.
- DONE: one cycle with `pmem_resp` low and requests ignored, then IDLE. The cycle gap prevents a held request from retriggering.
- Address and request inputs that change after latching are ignored until IDLE.
- A request dropped mid-WAIT or mid-BURST does not abort the burst. A write still stores whatever `pmem_wdata` shows on each beat.
- Read after write to the same line returns the new data. There is no write buffering.
- Reset values: state IDLE, `pmem_resp` 0, `pmem_rdata` 0, `proto_err` 0, counters 0.
- Line-store contents are not touched by `rst`. Simulation initializes them to 0.
- Reset mid-burst: return to IDLE on the next edge. A partially written line keeps the beats already stored.

## Timing
- The request is first high in IDLE at cycle 0. Beat 0 `pmem_resp` is high in cycle `LATENCY`, beat 3 in cycle `LATENCY`+3, DONE is cycle `LATENCY`+4, and the next request is recognized no earlier than cycle `LATENCY`+5.
- Total occupancy per line is `LATENCY`+5 cycles.
- `pmem_rdata` and `pmem_resp` are driven from registers; there is no combinational path from inputs to outputs.
- Throughput is one outstanding request at a time; there is no pipelining across lines.

## Configuration
- `BURST_MEM_PROTO_CHECK_EN` defined: `proto_err` sets and holds until `rst` on any of these events:
  - read and write high together in IDLE;
  - request dropped during WAIT or BURST;
  - request high during DONE;
  - op switches between read and write mid-transaction.
- Not defined: `proto_err` is tied to 0 and the checker logic is absent. Data behaviour is identical in both builds.

## Structure
- Shared package `pmem_types`: `PMEM_BEATS`=4, `PMEM_BEAT_W`=64, `PMEM_LINE_W`=256, `PMEM_OFFSET_W`=5, and the FSM state enum `pmem_state_t`.
- Sub-module `line_ram`: 2^DEPTH_LOG2 × 4 × 64-bit array with one synchronous read port and one write port, addressed by {index, beat}.
- The FSM, counters and checker live in the top module.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0 throughout and after release.
- Write then read at `LATENCY`=6:
  - Stimulus: write line 0x0000_0040 with beats 0x1111_1111_1111_1111, 0x2222…, 0x3333…, 0x4444…, then read the same line.
  - Response: `pmem_resp` rises exactly 6 cycles after each request, and the read returns the 4 beats in order.
- Offset ignored: read at 0x0000_005C after the previous scenario → same 4 beats as line 0x40.
- Aliasing: with `DEPTH_LOG2`=4, write 0xDEAD… beats to line 0x0000_0200, then read 0x0000_0000 → 0xDEAD… beats.
- Back-to-back: write, then a read to a different line asserted in the cycle after DONE → second `pmem_resp` rises `LATENCY` cycles later, with correct data and no beat lost or duplicated.
- Protocol check (macro on):
  - Read and write asserted together → write is performed and `proto_err`=1 until `rst`.
  - With the macro off, the same stimulus keeps `proto_err`=0.

Source files
------------

// File: rtl/pmem_types.sv
// Shared definitions for the 64-bit physical-memory burst interface.
// Beat/line geometry and the responder FSM state type.
// Imported by the responder top and its line store.
package pmem_types;

    localparam int PMEM_BEATS    = 4;
    localparam int PMEM_BEAT_W   = 64;
    localparam int PMEM_LINE_W   = 256;
    localparam int PMEM_OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } pmem_state_t;

endpackage

// File: rtl/burst_mem_responder_line_ram.sv
// Line store: 2^DEPTH_LOG2 lines x 4 beats x 64 bits, addressed by {index, beat}.
// Latency: read data appears one cycle after rd_en; writes land at the clock edge.
// Backpressure: none; one read and one write port, always ready.
module line_ram
    import pmem_types::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [DEPTH_LOG2+1:0]    rd_addr,
    output logic [PMEM_BEAT_W-1:0]   rd_dat,
    input  logic                     wr_en,
    input  logic [DEPTH_LOG2+1:0]    wr_addr,
    input  logic [PMEM_BEAT_W-1:0]   wr_dat
);

    localparam int WORDS = (2 ** DEPTH_LOG2) * PMEM_BEATS;

    logic [PMEM_BEAT_W-1:0] mem [WORDS];
    logic [PMEM_BEAT_W-1:0] rd_dat_q;
    logic [PMEM_BEAT_W-1:0] rd_dat_d;

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read data is zero whenever no read is issued so the bus idles at 0.
    always_comb begin
        rd_dat_d = '0;
        if (rd_en) begin
            rd_dat_d = mem[rd_addr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side burst responder: one line request, LATENCY-cycle wait, 4-beat response.
// Latency: first beat LATENCY cycles after request; LATENCY+5 cycles per line.
// Backpressure: one outstanding request; requests held by the requester until done.
// Optional BURST_MEM_PROTO_CHECK_EN adds a sticky protocol-violation flag.
module burst_mem_responder
    import pmem_types::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [31:0]            pmem_address,
    input  logic [PMEM_BEAT_W-1:0] pmem_wdata,
    output logic                   pmem_resp,
    output logic [PMEM_BEAT_W-1:0] pmem_rdata,
    output logic                   proto_err
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    pmem_state_t            state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [1:0]             beat_q, beat_d;
    logic                   op_wr_q, op_wr_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic                   resp_q, resp_d;

    logic                   req;
    logic                   ram_rd_en;
    logic                   ram_wr_en;
    logic [DEPTH_LOG2+1:0]  ram_rd_addr;
    logic [DEPTH_LOG2+1:0]  ram_wr_addr;
    logic                   unused_addr_bits;

    assign req = pmem_read | pmem_write;

    // Line offset and aliasing bits above the index carry no meaning here.
    assign unused_addr_bits = ^{pmem_address[31:PMEM_OFFSET_W+DEPTH_LOG2],
                                pmem_address[PMEM_OFFSET_W-1:0]};

    // Next-state logic: latch request, count down latency, walk four beats, idle one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_wr_d = pmem_write;
                    idx_d   = pmem_address[PMEM_OFFSET_W +: DEPTH_LOG2];
                    beat_d  = 2'd0;
                    cnt_d   = LAT_M1;
                    // A latency of one skips the wait state entirely.
                    state_d = (LAT_M1 == 8'd0) ? ST_BURST : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    beat_d  = 2'd0;
                    state_d = ST_BURST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_BURST: begin
                if (beat_q == 2'(PMEM_BEATS - 1)) begin
                    beat_d  = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response and read issue are computed one cycle ahead so both leave flops.
    always_comb begin
        resp_d      = (state_d == ST_BURST);
        ram_rd_en   = resp_d && !op_wr_d;
        ram_rd_addr = {idx_d, beat_d};
        ram_wr_en   = (state_q == ST_BURST) && op_wr_q && !rst;
        ram_wr_addr = {idx_q, beat_q};
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            resp_q  <= resp_d;
        end
    end

    line_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_line_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_dat  (pmem_rdata),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_dat  (pmem_wdata)
    );

    assign pmem_resp = resp_q;

`ifdef BURST_MEM_PROTO_CHECK_EN
    logic err_q, err_d;
    logic viol;

    // Flag requester misbehaviour: conflicting ops, dropped or switched requests, early reissue.
    always_comb begin
        viol = 1'b0;
        case (state_q)
            ST_IDLE:  viol = pmem_read & pmem_write;
            ST_WAIT,
            ST_BURST: viol = op_wr_q ? !pmem_write : (pmem_write | !pmem_read);
            ST_DONE:  viol = req;
            default:  viol = 1'b0;
        endcase
        err_d = err_q | viol;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: directed scenarios plus randomized line traffic.
// Expected beats come from a per-line array model indexed by (address/32) mod depth.
// Inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_burst_mem_responder;

    localparam int D   = 4;
    localparam int NL  = 16;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;
    logic        proto_err;

    int vectors = 0;
    int errors  = 0;

    logic [255:0] model [NL];
    bit           written [NL];
    logic         exp_err;

    always #5 clk = ~clk;

    burst_mem_responder #(
        .DEPTH_LOG2 (D),
        .LATENCY    (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .proto_err    (proto_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32) % NL);
    endfunction

    // One full transaction starting in an idle cycle; optional reset at cycle rst_at.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [255:0] line, input int rst_at, input string tag);
        int ix;
        ix = idx_of(addr);
        for (int c = 0; c < LAT + 5; c++) begin
            bit in_burst;
            int b;
            logic [63:0] exp_rd;
            in_burst = (c >= LAT) && (c < LAT + 4);
            b        = c - LAT;
            if (c == 0) begin
                pmem_write   = wr;
                pmem_read    = rd;
                pmem_address = addr;
            end else if (c < LAT + 4) begin
                pmem_address = $urandom;
            end else begin
                pmem_write = 1'b0;
                pmem_read  = 1'b0;
            end
            if (in_burst && wr) pmem_wdata = line[64*b +: 64];
            else                pmem_wdata = {$urandom, $urandom};
            if (c == rst_at) rst = 1'b1;
            @(negedge clk);
            exp_rd = '0;
            if (in_burst && !wr) exp_rd = model[ix][64*b +: 64];
            check({tag, "_resp"}, 64'(pmem_resp), 64'(in_burst));
            check({tag, "_rdata"}, pmem_rdata, exp_rd);
            check({tag, "_err"}, 64'(proto_err), 64'(exp_err));
            if (in_burst && wr && c != rst_at) model[ix][64*b +: 64] = line[64*b +: 64];
            @(posedge clk);
            #1;
`ifdef BURST_MEM_PROTO_CHECK_EN
            if (c == 0 && wr && rd) exp_err = 1'b1;
`endif
            if (c == rst_at) begin
                rst        = 1'b0;
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
                exp_err    = 1'b0;
                return;
            end
        end
        if (wr) written[ix] = 1'b1;
    endtask

    initial begin
        logic [255:0] ln;
        logic [31:0]  a;
        int           ix;

        for (int i = 0; i < NL; i++) begin
            model[i]   = '0;
            written[i] = 1'b0;
        end
        exp_err      = 1'b0;
        rst          = 1'b1;
        pmem_read    = $urandom;
        pmem_write   = $urandom;
        pmem_address = $urandom;
        pmem_wdata   = {$urandom, $urandom};
        @(posedge clk);
        #1;

        // Reset held with random inputs.
        for (int i = 0; i < 2; i++) begin
            pmem_read    = $urandom;
            pmem_write   = $urandom;
            pmem_address = $urandom;
            pmem_wdata   = {$urandom, $urandom};
            @(negedge clk);
            check("rst_resp", 64'(pmem_resp), 64'd0);
            check("rst_rdata", pmem_rdata, 64'd0);
            check("rst_err", 64'(proto_err), 64'd0);
            @(posedge clk);
            #1;
        end
        rst        = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        check("post_rst_resp", 64'(pmem_resp), 64'd0);
        check("post_rst_rdata", pmem_rdata, 64'd0);
        check("post_rst_err", 64'(proto_err), 64'd0);
        @(posedge clk);
        #1;

        // Write then read line 0x40, offset-ignored read at 0x5C.
        ln = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        txn(1'b1, 1'b0, 32'h0000_0040, ln, -1, "wr40");
        txn(1'b0, 1'b1, 32'h0000_0040, '0, -1, "rd40");
        txn(1'b0, 1'b1, 32'h0000_005C, '0, -1, "rd5c");

        // Aliasing: 0x200 and 0x000 share index 0 with 16 lines.
        ln = {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002,
              64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
        txn(1'b1, 1'b0, 32'h0000_0200, ln, -1, "wr200");
        txn(1'b0, 1'b1, 32'h0000_0000, '0, -1, "rd000");

        // Back-to-back: write, then read of another line in the cycle after DONE.
        ln = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 1'b0, 32'h0000_01A0, ln, -1, "wr1a0");
        txn(1'b0, 1'b1, 32'h0000_0040, '0, -1, "b2b_rd40");
        txn(1'b0, 1'b1, 32'h0000_01A0, '0, -1, "rd1a0");

        // Randomized traffic over all lines.
        for (int n = 0; n < 30; n++) begin
            ix = int'($urandom_range(NL - 1, 0));
            a  = ($urandom & 32'hFFFF_FE1F) | (32'(ix) << 5);
            if (!written[ix] || $urandom_range(1, 0) == 1) begin
                ln = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
                txn(1'b1, 1'b0, a, ln, -1, "rnd_wr");
            end else begin
                txn(1'b0, 1'b1, a, '0, -1, "rnd_rd");
            end
        end

        // Read and write together: write wins.
        ln = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 1'b1, 32'h0000_0060, ln, -1, "rdwr");
        txn(1'b0, 1'b1, 32'h0000_0060, '0, -1, "rdwr_chk");

        // Reset during beat 2 of a write: beats 0 and 1 stay, 2 and 3 keep old data.
        ln = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        txn(1'b1, 1'b0, 32'h0000_0060, ln, LAT + 2, "rstmid");
        txn(1'b0, 1'b1, 32'h0000_0060, '0, -1, "rstmid_chk");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
